// File: rtl/instr_encoder.sv
// Packs RV32 instruction field bundles into 32-bit words and streams them to
// instruction memory through a 2-entry FIFO, one load session per start pulse.
module instr_encoder #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [2:0]         fmt,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [11:0]        immed,
    input  logic [9:0]         func,
    input  logic [19:0]        joffset,
    output logic               imem_we,
    input  logic               imem_ready,
    output logic [31:0]        imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               done,
    output logic               err_illegal,
    output logic [COUNT_W-1:0] instr_count
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_J = 7'b1101111;
    localparam logic [6:0] OP_L = 7'b0000011;

    state_t             state_q, state_d;
    logic [31:0]        slot0_q, slot0_d, slot1_q, slot1_d;
    logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]         occ_q, occ_d;
    logic [31:0]        addr_q, addr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               err_q, err_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept, push, pop;
    logic [31:0] head;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (fmt)
            3'd0: enc_word = {func[9:3], rs2, rs1, func[2:0], rd, OP_R};
            3'd1: enc_word = {immed, rs1, func[2:0], rd, OP_I};
            3'd2: enc_word = {immed[11:5], rs2, rs1, func[2:0], immed[4:0], OP_S};
            3'd3: enc_word = {immed[11], immed[9:4], rs2, rs1, func[2:0],
                              immed[3:0], immed[10], OP_B};
            3'd4: enc_word = {joffset[19], joffset[9:0], joffset[10],
                              joffset[18:11], rd, OP_J};
            3'd5: enc_word = {immed, rs1, func[2:0], rd, OP_L};
            default: enc_legal = 1'b0;
        endcase
    end

    // in_ready depends only on registered state so imem_ready never reaches it.
    assign in_ready    = (state_q == RUN) && (occ_q != 2'd2);
    assign imem_we     = ((state_q == RUN) || (state_q == DRAIN)) && (occ_q != 2'd0);
    assign head        = rd_ptr_q ? slot1_q : slot0_q;
    assign imem_wdata  = imem_we ? head : 32'd0;
    assign imem_addr   = addr_q;
    assign done        = (state_q == DONE);
    assign err_illegal = err_q;
    assign instr_count = count_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && enc_legal;
    assign pop    = imem_we && imem_ready;

    always_comb begin
        state_d  = state_q;
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
        addr_d   = addr_q;
        count_d  = count_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    addr_d  = {base_addr[31:2], 2'b00};
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (accept && in_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (occ_q == 2'd0) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept && !enc_legal) err_d = 1'b1;

        if (push) begin
            if (wr_ptr_q) slot1_d = enc_word;
            else          slot0_d = enc_word;
            wr_ptr_d = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            addr_d   = addr_q + 32'd4;
            if (count_q != {COUNT_W{1'b1}}) count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            slot0_q  <= '0;
            slot1_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
            addr_q   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot0_q  <= slot0_d;
            slot1_q  <= slot1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// sessions compared against an ISA-level encoding model and a write queue.
module tb_instr_encoder;
    localparam int COUNT_W = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [31:0]        base_addr = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_last = 1'b0;
    logic [2:0]         fmt = '0;
    logic [4:0]         rd = '0, rs1 = '0, rs2 = '0;
    logic [11:0]        immed = '0;
    logic [9:0]         func = '0;
    logic [19:0]        joffset = '0;
    logic               imem_we;
    logic               imem_ready;
    logic [31:0]        imem_addr;
    logic [31:0]        imem_wdata;
    logic               done;
    logic               err_illegal;
    logic [COUNT_W-1:0] instr_count;

    logic rand_ready = 1'b0;
    logic ready_force = 1'b1;
    logic rand_bit = 1'b1;

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;

    logic [31:0] obs_addr[$], obs_data[$];
    logic [31:0] exp_addr[$], exp_data[$];
    logic [31:0] next_addr;

    instr_encoder #(.COUNT_W(COUNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .immed(immed),
        .func(func), .joffset(joffset), .imem_we(imem_we),
        .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .done(done), .err_illegal(err_illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign imem_ready = rand_ready ? rand_bit : ready_force;

    always @(posedge clk) begin
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end

    // A write completes on the next rising edge when both handshake halves are high.
    always @(negedge clk) begin
        if (imem_we && imem_ready && !reset) begin
            obs_addr.push_back(imem_addr);
            obs_data.push_back(imem_wdata);
        end
        if (done) done_cnt++;
    end

    // ISA-level model: rebuild the real byte offsets, then place their bits.
    function automatic logic [31:0] ref_encode(input logic [2:0] f, input logic [4:0] d,
            input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im,
            input logic [9:0] fn, input logic [19:0] jo);
        logic [31:0] f3, f7, imm, off, base_fields;
        f3  = 32'(fn[2:0]);
        f7  = 32'(fn[9:3]);
        imm = 32'(im);
        base_fields = (f3 << 12) | (32'(s1) << 15);
        case (f)
            3'd0: return 32'h33 | (32'(d) << 7) | base_fields | (32'(s2) << 20) | (f7 << 25);
            3'd1: return 32'h13 | (32'(d) << 7) | base_fields | (imm << 20);
            3'd5: return 32'h03 | (32'(d) << 7) | base_fields | (imm << 20);
            3'd2: return 32'h23 | ((imm & 32'h1F) << 7) | base_fields
                         | (32'(s2) << 20) | ((imm >> 5) << 25);
            3'd3: begin
                off = (32'(im[11]) << 12) | (32'(im[10]) << 11)
                    | (32'(im[9:4]) << 5) | (32'(im[3:0]) << 1);
                return 32'h63 | (((off >> 11) & 32'h1) << 7) | (((off >> 1) & 32'hF) << 8)
                     | base_fields | (32'(s2) << 20) | (((off >> 5) & 32'h3F) << 25)
                     | (((off >> 12) & 32'h1) << 31);
            end
            3'd4: begin
                off = (32'(jo[19]) << 20) | (32'(jo[18:11]) << 12)
                    | (32'(jo[10]) << 11) | (32'(jo[9:0]) << 1);
                return 32'h6F | (32'(d) << 7) | (((off >> 12) & 32'hFF) << 12)
                     | (((off >> 11) & 32'h1) << 20) | (((off >> 1) & 32'h3FF) << 21)
                     | (((off >> 20) & 32'h1) << 31);
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic begin_session(input logic [31:0] base, output int os);
        repeat (2) begin @(posedge clk); #1; end
        exp_addr.delete();
        exp_data.delete();
        next_addr = {base[31:2], 2'b00};
        os = obs_addr.size();
        base_addr = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [2:0] f, input logic [4:0] d, input logic [4:0] s1,
            input logic [4:0] s2, input logic [11:0] im, input logic [9:0] fn,
            input logic [19:0] jo, input logic last);
        bit acc;
        acc = 1'b0;
        fmt = f; rd = d; rs1 = s1; rs2 = s2; immed = im; func = fn; joffset = jo;
        in_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin acc = 1'b1; break; end
        end
        if (acc) begin
            @(posedge clk);
            if (f < 3'd6) begin
                exp_addr.push_back(next_addr);
                exp_data.push_back(ref_encode(f, d, s1, s2, im, fn, jo));
                next_addr += 32'd4;
            end
        end else begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL send_timeout: in_ready stayed 0 for 100 cycles, required 1");
        end
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({in_ready, imem_we, done, err_illegal, imem_addr, imem_wdata, instr_count} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got rdy=%b we=%b done=%b err=%b addr=%h data=%h cnt=%0d, required all 0",
                     in_ready, imem_we, done, err_illegal, imem_addr, imem_wdata, instr_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single_i();
        int os; bit ok;
        ready_force = 1'b1;
        begin_session(32'h1000, os);
        send(3'd1, 5'd1, 5'd0, 5'd0, 12'd5, 10'd0, 20'd0, 1'b1);
        @(negedge clk);
        tests_run++;
        if (imem_we !== 1'b1 || imem_addr !== 32'h1000 || imem_wdata !== 32'h00500093) begin
            tests_failed++;
            $display("[TB] FAIL single_latency: got we=%b addr=%h data=%h, required we=1 addr=00001000 data=00500093",
                     imem_we, imem_addr, imem_wdata);
        end
        wait_done(ok);
        tests_run++;
        if (!ok || instr_count !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL single_done: got done_seen=%b count=%0d, required 1 and 1", ok, instr_count);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL done_width: got done=%b one cycle later, required 0", done);
        end
        tests_run++;
        if (obs_addr.size() != os + 1 || obs_addr[os] !== 32'h1000 || obs_data[os] !== 32'h00500093) begin
            tests_failed++;
            $display("[TB] FAIL single_write: got %0d writes first %h@%h, required 1 write 00500093@00001000",
                     obs_addr.size() - os, obs_data[os], obs_addr[os]);
        end
    endtask

    task automatic test_r_j();
        int os; bit ok;
        begin_session(32'h2000, os);
        send(3'd0, 5'd3, 5'd1, 5'd2, 12'd0, 10'd0, 20'd0, 1'b0);
        start = 1'b1;
        base_addr = 32'h9000;
        @(posedge clk); #1;
        start = 1'b0;
        send(3'd4, 5'd1, 5'd0, 5'd0, 12'd0, 10'd0, 20'd1, 1'b1);
        wait_done(ok);
        tests_run++;
        if (!ok || obs_addr.size() != os + 2) begin
            tests_failed++;
            $display("[TB] FAIL rj_count: got done_seen=%b writes=%0d, required 1 and 2", ok, obs_addr.size() - os);
        end else begin
            tests_run++;
            if (obs_data[os] !== 32'h002081B3 || obs_addr[os] !== 32'h2000) begin
                tests_failed++;
                $display("[TB] FAIL rj_r_word: got %h@%h, required 002081b3@00002000", obs_data[os], obs_addr[os]);
            end
            tests_run++;
            if (obs_data[os+1] !== 32'h002000EF || obs_addr[os+1] !== 32'h2004) begin
                tests_failed++;
                $display("[TB] FAIL rj_j_word: got %h@%h, required 002000ef@00002004", obs_data[os+1], obs_addr[os+1]);
            end
        end
    endtask

    task automatic test_bs_random();
        int os; bit ok;
        logic [2:0]  f_a[8];
        logic [4:0]  s1_a[8], s2_a[8];
        logic [11:0] im_a[8];
        logic [9:0]  fn_a[8];
        logic [31:0] base, w;
        logic [11:0] dec_im;
        logic [6:0]  exp_op;
        base = $urandom & 32'hFFFF_FFF0;
        begin_session(base, os);
        for (int i = 0; i < 8; i++) begin
            f_a[i]  = (i % 2 == 0) ? 3'd2 : 3'd3;
            s1_a[i] = 5'($urandom); s2_a[i] = 5'($urandom);
            im_a[i] = 12'($urandom); fn_a[i] = 10'($urandom);
            send(f_a[i], 5'($urandom), s1_a[i], s2_a[i], im_a[i], fn_a[i], 20'($urandom), i == 7);
        end
        wait_done(ok);
        tests_run++;
        if (!ok || obs_addr.size() != os + 8) begin
            tests_failed++;
            $display("[TB] FAIL bs_count: got done_seen=%b writes=%0d, required 1 and 8", ok, obs_addr.size() - os);
        end else begin
            for (int i = 0; i < 8; i++) begin
                w = obs_data[os+i];
                dec_im = (f_a[i] == 3'd2) ? {w[31:25], w[11:7]} : {w[31], w[7], w[30:25], w[11:8]};
                exp_op = (f_a[i] == 3'd2) ? 7'h23 : 7'h63;
                tests_run++;
                if ({w[6:0], w[19:15], w[24:20], w[14:12], dec_im} !== {exp_op, s1_a[i], s2_a[i], fn_a[i][2:0], im_a[i]}
                    || obs_addr[os+i] !== base + 32'(4 * i)) begin
                    tests_failed++;
                    $display("[TB] FAIL bs_decode[%0d]: got word %h@%h, required op=%h rs1=%0d rs2=%0d f3=%0d imm=%h @%h",
                             i, w, obs_addr[os+i], exp_op, s1_a[i], s2_a[i], fn_a[i][2:0], im_a[i], base + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int os; bit ok;
        ready_force = 1'b0;
        begin_session(32'h4000, os);
        send(3'd0, 5'd4, 5'd5, 5'd6, 12'd0, 10'h155, 20'd0, 1'b0);
        send(3'd1, 5'd7, 5'd8, 5'd0, 12'h7FF, 10'd2, 20'd0, 1'b0);
        fmt = 3'd5; rd = 5'd9; rs1 = 5'd10; immed = 12'h800; func = 10'd3; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0 || imem_we !== 1'b1 || imem_addr !== 32'h4000 || imem_wdata !== exp_data[0]) begin
                tests_failed++;
                $display("[TB] FAIL bp_hold[%0d]: got rdy=%b we=%b addr=%h data=%h, required 0 1 00004000 %h",
                         i, in_ready, imem_we, imem_addr, imem_wdata, exp_data[0]);
            end
        end
        ready_force = 1'b1;
        send(3'd5, 5'd9, 5'd10, 5'd0, 12'h800, 10'd3, 20'd0, 1'b1);
        wait_done(ok);
        tests_run++;
        if (!ok || obs_addr.size() != os + 3 || instr_count !== 16'd3) begin
            tests_failed++;
            $display("[TB] FAIL bp_count: got done_seen=%b writes=%0d count=%0d, required 1 3 3",
                     ok, obs_addr.size() - os, instr_count);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (obs_addr[os+i] !== exp_addr[i] || obs_data[os+i] !== exp_data[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_order[%0d]: got %h@%h, required %h@%h",
                             i, obs_data[os+i], obs_addr[os+i], exp_data[i], exp_addr[i]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        int os; bit ok;
        begin_session(32'h3000, os);
        send(3'd1, 5'd2, 5'd3, 5'd0, 12'h123, 10'd0, 20'd0, 1'b0);
        send(3'd7, 5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom), 10'($urandom), 20'($urandom), 1'b0);
        send(3'd0, 5'd4, 5'd5, 5'd6, 12'd0, 10'h3FF, 20'd0, 1'b1);
        wait_done(ok);
        tests_run++;
        if (!ok || err_illegal !== 1'b1 || instr_count !== 16'd2 || obs_addr.size() != os + 2) begin
            tests_failed++;
            $display("[TB] FAIL illegal_mid: got done_seen=%b err=%b count=%0d writes=%0d, required 1 1 2 2",
                     ok, err_illegal, instr_count, obs_addr.size() - os);
        end else begin
            tests_run++;
            if (obs_addr[os] !== 32'h3000 || obs_addr[os+1] !== 32'h3004
                || obs_data[os] !== exp_data[0] || obs_data[os+1] !== exp_data[1]) begin
                tests_failed++;
                $display("[TB] FAIL illegal_words: got %h@%h %h@%h, required %h@00003000 %h@00003004",
                         obs_data[os], obs_addr[os], obs_data[os+1], obs_addr[os+1], exp_data[0], exp_data[1]);
            end
        end
        begin_session(32'h5000, os);
        tests_run++;
        if (err_illegal !== 1'b0 || instr_count !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL start_clear: got err=%b count=%0d, required 0 0", err_illegal, instr_count);
        end
        send(3'd6, 5'd1, 5'd1, 5'd1, 12'd1, 10'd1, 20'd1, 1'b1);
        wait_done(ok);
        tests_run++;
        if (!ok || err_illegal !== 1'b1 || instr_count !== 16'd0 || obs_addr.size() != os) begin
            tests_failed++;
            $display("[TB] FAIL illegal_last: got done_seen=%b err=%b count=%0d writes=%0d, required 1 1 0 0",
                     ok, err_illegal, instr_count, obs_addr.size() - os);
        end
    endtask

    task automatic test_wrap();
        int os; bit ok;
        begin_session(32'hFFFF_FFFE, os);
        send(3'd1, 5'd1, 5'd2, 5'd0, 12'd8, 10'd0, 20'd0, 1'b0);
        send(3'd5, 5'd3, 5'd4, 5'd0, 12'd12, 10'd2, 20'd0, 1'b1);
        wait_done(ok);
        tests_run++;
        if (!ok || obs_addr.size() != os + 2 || obs_addr[os] !== 32'hFFFF_FFFC || obs_addr[os+1] !== 32'h0
            || obs_data[os+1] !== exp_data[1]) begin
            tests_failed++;
            $display("[TB] FAIL wrap: got done_seen=%b writes=%0d addrs %h %h, required 1 2 fffffffc 00000000",
                     ok, obs_addr.size() - os, obs_addr[os], obs_addr[os+1]);
        end
    endtask

    task automatic test_reset_mid();
        int os, wr_before, done_before;
        ready_force = 1'b0;
        begin_session(32'h6000, os);
        send(3'd1, 5'd1, 5'd1, 5'd0, 12'd1, 10'd0, 20'd0, 1'b0);
        send(3'd1, 5'd2, 5'd2, 5'd0, 12'd2, 10'd0, 20'd0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0 || imem_we !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_full: got rdy=%b we=%b, required 0 1", in_ready, imem_we);
        end
        reset = 1'b1;
        ready_force = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({in_ready, imem_we, done, err_illegal, imem_addr, imem_wdata, instr_count} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_outputs: got we=%b addr=%h data=%h cnt=%0d, required all 0",
                     imem_we, imem_addr, imem_wdata, instr_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        wr_before = obs_addr.size();
        done_before = done_cnt;
        repeat (20) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (obs_addr.size() != wr_before || done_cnt != done_before) begin
            tests_failed++;
            $display("[TB] FAIL mid_abort: got %0d writes %0d done pulses after reset, required 0 0",
                     obs_addr.size() - wr_before, done_cnt - done_before);
        end
    endtask

    task automatic test_random_stream();
        int os, n; bit ok, any_illegal;
        logic [2:0] f;
        rand_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            begin_session($urandom, os);
            n = $urandom_range(3, 10);
            any_illegal = 1'b0;
            for (int i = 0; i < n; i++) begin
                f = 3'($urandom_range(0, 7));
                if (f >= 3'd6) any_illegal = 1'b1;
                send(f, 5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom),
                     10'($urandom), 20'($urandom), i == n - 1);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            wait_done(ok);
            tests_run++;
            if (!ok || obs_addr.size() != os + exp_addr.size() || instr_count !== 16'(exp_addr.size())
                || err_illegal !== any_illegal) begin
                tests_failed++;
                $display("[TB] FAIL rand_session[%0d]: got done_seen=%b writes=%0d count=%0d err=%b, required 1 %0d %0d %b",
                         s, ok, obs_addr.size() - os, instr_count, err_illegal,
                         exp_addr.size(), exp_addr.size(), any_illegal);
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    tests_run++;
                    if (obs_addr[os+i] !== exp_addr[i] || obs_data[os+i] !== exp_data[i]) begin
                        tests_failed++;
                        $display("[TB] FAIL rand_word[%0d.%0d]: got %h@%h, required %h@%h",
                                 s, i, obs_data[os+i], obs_addr[os+i], exp_data[i], exp_addr[i]);
                    end
                end
            end
        end
        rand_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_i();
        test_r_j();
        test_bs_random();
        test_backpressure();
        test_illegal();
        test_wrap();
        test_reset_mid();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
